cpu_axi_master: RTL and testbench
=================================

# cpu_axi_master

Single-outstanding AXI4 master bridge that sits directly downstream of the five-stage CPU core's instruction-fetch and data-memory ports. One instance serves the IM port and one serves the DM port. Each instance turns a CPU level request (read/write, address, data, core_type) into one single-beat AXI4 transaction and holds `stall` high until the response returns. The captured read data and the stall release then drive the CPU's `im_dataout`/`dm_dataout` and `cpu_stall` inputs.

## Interface
- `MASTER_ID`, 4'd0, constant driven on ARID/AWID.
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width; only 32 is supported.

- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_read`  in  1  CPU read request (level).
- `req_write`  in  1  CPU write request (level).
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  DATA_W  write data, already lane-aligned by the CPU.
- `req_core_type`  in  3  access size: 0 = word, 1 = halfword, 2 = byte, others are treated as word.
- `req_rdata`  out  DATA_W  last captured read data.
- `stall`  out  1  CPU stall.
- `err`  out  1  sticky error flag (see Configuration).
- AR channel: `ARID`[3:0], `ARADDR`[ADDR_W], `ARLEN`[3:0], `ARSIZE`[2:0], `ARBURST`[1:0], `ARVALID` out; `ARREADY` in.
- R channel: `RID`[3:0], `RDATA`[DATA_W], `RRESP`[1:0], `RLAST`, `RVALID` in; `RREADY` out.
- AW channel: `AWID`, `AWADDR`, `AWLEN`, `AWSIZE`, `AWBURST`, `AWVALID` out; `AWREADY` in.
- W channel: `WDATA`[DATA_W], `WSTRB`[3:0], `WLAST`, `WVALID` out; `WREADY` in.
- B channel: `BID`[3:0], `BRESP`[1:0], `BVALID` in; `BREADY` out.

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, DONE.
- IDLE:
  - `req_write` → WR. Write has priority when both requests are high; the read is dropped and is not replayed.
  - `req_read` alone → RD_ADDR.
  - Address, wdata and size are latched on the transition.
- RD_ADDR: ARVALID=1. On ARVALID&ARREADY → RD_DATA.
- RD_DATA: RREADY=1. On RVALID&RREADY:
  - capture RDATA into `req_rdata`;
  - → DONE.
- WR:
  - AWVALID and WVALID are raised together.
  - Each drops independently after its own handshake; a per-channel done flag records it.
  - → WR_RESP once both handshakes are complete, including when both complete in the same cycle.
- WR_RESP: BREADY=1. On BVALID → DONE.
- DONE:
  - One cycle, with stall low.
  - Request inputs are ignored; they still show the retiring request.
  - → IDLE.
- Fixed fields:
  - ARLEN/AWLEN = 0.
  - ARBURST/AWBURST = 2'b01 (INCR).
  - WLAST = 1.
- ARSIZE/AWSIZE = 2 / 1 / 0 for word / half / byte.
- WSTRB, from the latched `addr[1:0]`:
  - word: 4'b1111.
  - half: 4'b0011 << {addr[1], 1'b0}.
  - byte: 4'b0001 << addr[1:0].
- RID and BID are not checked; there is only one transaction outstanding.
- AXI address, data and control outputs are registered from the latched request. They stay stable while VALID is high and READY is low.

## Timing
- `stall` = (IDLE & (req_read | req_write)) | state ∈ {RD_ADDR, RD_DATA, WR, WR_RESP}. It is combinational on the request in IDLE only.
- Minimum read with READY/VALID tied high:
  - c0 IDLE detect;
  - c1 ARVALID;
  - c2 RREADY/RVALID;
  - c3 DONE, with `req_rdata` valid and stall low.
  - Stall is high for 3 cycles.
- Minimum write: c0 detect, c1 AW+W, c2 B, c3 DONE. Stall is high for 3 cycles.
- Wait states on any channel extend the stall one-for-one.
- `req_rdata` holds its value until the next R handshake.
- Reset values:
  - all VALID/READY outputs = 0;
  - `req_rdata` = 0, `stall` = 0, `err` = 0;
  - address/data outputs = 0;
  - state = IDLE.
- Reset mid-transaction aborts immediately, with VALIDs dropped asynchronously. This is legal only under a system-wide reset.

## Configuration
- `CPU_AXI_MASTER_RESP_CHECK_EN` defined:
  - RRESP or BRESP ≠ 2'b00 sets `err`; `err` stays set until `rst`.
  - A read with an error response loads `req_rdata` = 0.
- `CPU_AXI_MASTER_RESP_CHECK_EN` undefined:
  - responses are ignored;
  - `err` is tied to 0;
  - RDATA is always captured.

## Test plan
- Read at addr 0x0000_0010, ARREADY=RVALID=1, RDATA=0xDEAD_BEEF → ARADDR=0x10, ARSIZE=2, stall high 3 cycles, `req_rdata`=0xDEADBEEF in DONE.
- Byte write at addr 0x0000_0023, wdata 0xAB00_0000, WREADY delayed 4 cycles after AWREADY → WSTRB=4'b1000, AWSIZE=0, AWVALID drops after 1 cycle, stall high 7 cycles.
- req_read & req_write both high, addr 0x40 → only AW/W issued, no ARVALID seen during the whole transaction.
- Halfword read at 0x0000_0006 with RRESP=2'b10, macro defined → ARSIZE=1, `err`=1, `req_rdata`=0; with the macro undefined, `err`=0 and RDATA is captured.
- Assert `rst` while in RD_DATA with RVALID=0 → ARVALID/RREADY/stall = 0 in the same cycle, state IDLE; a new read after reset completes normally.
- Request held high in DONE → no second transaction; next request is accepted only from IDLE.

Source files
------------

// File: rtl/cpu_axi_master_if.sv
// ---------------------------------------------------------------------------
// cpu_axi_master_if
// Purpose : AXI4 channel bundle between cpu_axi_master and its slave.
//           Only single-beat transfers are used, but the full set of
//           single-beat fields is carried so the bus looks like plain AXI4.
// Signals : AR (ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID/ARREADY)
//           R  (RID/RDATA/RRESP/RLAST/RVALID/RREADY)
//           AW (AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID/AWREADY)
//           W  (WDATA/WSTRB/WLAST/WVALID/WREADY)
//           B  (BID/BRESP/BVALID/BREADY)
// Modports: master (bridge side), slave (memory / interconnect side)
// ---------------------------------------------------------------------------
interface cpu_axi_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [3:0]          ARID;
  logic [ADDR_W-1:0]   ARADDR;
  logic [3:0]          ARLEN;
  logic [2:0]          ARSIZE;
  logic [1:0]          ARBURST;
  logic                ARVALID;
  logic                ARREADY;

  logic [3:0]          RID;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RLAST;
  logic                RVALID;
  logic                RREADY;

  logic [3:0]          AWID;
  logic [ADDR_W-1:0]   AWADDR;
  logic [3:0]          AWLEN;
  logic [2:0]          AWSIZE;
  logic [1:0]          AWBURST;
  logic                AWVALID;
  logic                AWREADY;

  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WLAST;
  logic                WVALID;
  logic                WREADY;

  logic [3:0]          BID;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY,
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY
  );

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY,
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY
  );
endinterface

// File: rtl/cpu_axi_master.sv
// ---------------------------------------------------------------------------
// cpu_axi_master
// Purpose : Single-outstanding AXI4 master bridge for one CPU memory port
//           (IM or DM). A level read/write request becomes one single-beat
//           AXI4 transaction; stall is held until the response returns,
//           followed by one DONE cycle with stall low.
// Ports   : clk, rst (asynchronous, active-high)
//           req_read, req_write, req_addr, req_wdata, req_core_type (in)
//           req_rdata, stall, err (out)
//           axi : cpu_axi_master_if.master
// Config  : `define CPU_AXI_MASTER_RESP_CHECK_EN to flag non-OKAY RRESP/BRESP
//           on the sticky err output and return zero data on a failed read.
//           Left undefined, responses are ignored and err is tied low.
// ---------------------------------------------------------------------------
module cpu_axi_master #(
  parameter logic [3:0] MASTER_ID = 4'd0,
  parameter int         ADDR_W    = 32,
  parameter int         DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [2:0]        req_core_type,
  output logic [DATA_W-1:0] req_rdata,
  output logic              stall,
  output logic              err,
  cpu_axi_master_if.master  axi
);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, DONE
  } state_t;

  state_t            r_state, w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [2:0]        r_size;
  logic [3:0]        r_strb;
  logic              r_aw_done, r_w_done;

  logic              w_start;
  logic [2:0]        w_size;
  logic [3:0]        w_strb;
  logic              w_arvalid, w_rready, w_awvalid, w_wvalid, w_bready;
  logic              w_stall;
  logic              w_aw_ok, w_w_ok;

  assign w_start = (r_state == IDLE) && (req_read || req_write);

  // Size and byte-lane strobe for the incoming request; registered on start.
  always_comb begin
    w_size = 3'd2;
    w_strb = 4'b1111;
    case (req_core_type)
      3'd1: begin
        w_size = 3'd1;
        w_strb = 4'b0011 << {req_addr[1], 1'b0};
      end
      3'd2: begin
        w_size = 3'd0;
        w_strb = 4'b0001 << req_addr[1:0];
      end
      default: ;
    endcase
  end

  // A channel counts as finished if it handshook earlier or handshakes now,
  // so simultaneous AW/W completion also leaves WR in one step.
  assign w_aw_ok = r_aw_done || (axi.AWVALID && axi.AWREADY);
  assign w_w_ok  = r_w_done  || (axi.WVALID  && axi.WREADY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    w_arvalid    = 1'b0;
    w_rready     = 1'b0;
    w_awvalid    = 1'b0;
    w_wvalid     = 1'b0;
    w_bready     = 1'b0;
    case (r_state)
      IDLE: begin
        // Write wins when both are requested; the read is simply dropped.
        if (req_write) begin
          w_stall      = 1'b1;
          w_state_next = WR;
        end else if (req_read) begin
          w_stall      = 1'b1;
          w_state_next = RD_ADDR;
        end
      end
      RD_ADDR: begin
        w_stall   = 1'b1;
        w_arvalid = 1'b1;
        if (axi.ARREADY) w_state_next = RD_DATA;
      end
      RD_DATA: begin
        w_stall  = 1'b1;
        w_rready = 1'b1;
        if (axi.RVALID) w_state_next = DONE;
      end
      WR: begin
        w_stall   = 1'b1;
        w_awvalid = !r_aw_done;
        w_wvalid  = !r_w_done;
        if (w_aw_ok && w_w_ok) w_state_next = WR_RESP;
      end
      WR_RESP: begin
        w_stall  = 1'b1;
        w_bready = 1'b1;
        if (axi.BVALID) w_state_next = DONE;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Stall must read low while reset is held, even with a request pending.
  assign stall = w_stall && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_size    <= '0;
      r_strb    <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      if (w_start) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_size  <= w_size;
        r_strb  <= w_strb;
      end
      r_aw_done <= (r_state == WR) && (w_state_next == WR) && w_aw_ok;
      r_w_done  <= (r_state == WR) && (w_state_next == WR) && w_w_ok;
      if ((r_state == RD_DATA) && axi.RVALID) begin
`ifdef CPU_AXI_MASTER_RESP_CHECK_EN
        r_rdata <= (axi.RRESP != 2'b00) ? '0 : axi.RDATA;
`else
        r_rdata <= axi.RDATA;
`endif
      end
    end
  end

`ifdef CPU_AXI_MASTER_RESP_CHECK_EN
  logic r_err;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      if ((r_state == RD_DATA) && axi.RVALID && (axi.RRESP != 2'b00)) r_err <= 1'b1;
      if ((r_state == WR_RESP) && axi.BVALID && (axi.BRESP != 2'b00)) r_err <= 1'b1;
    end
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign req_rdata   = r_rdata;

  assign axi.ARID    = MASTER_ID;
  assign axi.ARADDR  = r_addr;
  assign axi.ARLEN   = 4'd0;
  assign axi.ARSIZE  = r_size;
  assign axi.ARBURST = 2'b01;
  assign axi.ARVALID = w_arvalid;
  assign axi.RREADY  = w_rready;

  assign axi.AWID    = MASTER_ID;
  assign axi.AWADDR  = r_addr;
  assign axi.AWLEN   = 4'd0;
  assign axi.AWSIZE  = r_size;
  assign axi.AWBURST = 2'b01;
  assign axi.AWVALID = w_awvalid;

  assign axi.WDATA   = r_wdata;
  assign axi.WSTRB   = r_strb;
  assign axi.WLAST   = 1'b1;
  assign axi.WVALID  = w_wvalid;
  assign axi.BREADY  = w_bready;

endmodule

// File: tb/tb_cpu_axi_master.sv
// ---------------------------------------------------------------------------
// tb_cpu_axi_master
// Purpose : Self-checking bench for cpu_axi_master. A behavioural AXI slave
//           with programmable per-channel wait states answers every request;
//           expected addresses, sizes, strobes, stall lengths, read data and
//           error flag come from a transaction-level model of the bridge.
// ---------------------------------------------------------------------------
module tb_cpu_axi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_read, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_core_type;
  logic [31:0] req_rdata;
  logic        stall, err;

  cpu_axi_master_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  cpu_axi_master #(.MASTER_ID(4'd0), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_core_type(req_core_type),
    .req_rdata(req_rdata), .stall(stall), .err(err),
    .axi(axi)
  );

  always #5 clk = ~clk;

  assign axi.RID   = 4'd0;
  assign axi.BID   = 4'd0;
  assign axi.RLAST = 1'b1;

  // Slave configuration, written by the main sequence only.
  int          ar_d, r_d, aw_d, w_d, b_d;
  logic [31:0] s_rdata;
  logic [1:0]  s_resp;

  // Slave observations, written by the slave process only.
  int          stall_cnt, ar_seen, aw_seen, b_hs;
  logic [31:0] got_araddr, got_awaddr, got_wdata;
  logic [2:0]  got_arsize, got_awsize;
  logic [3:0]  got_arlen, got_awlen, got_strb, got_arid;
  logic [1:0]  got_arburst, got_awburst;
  logic        got_wlast;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural slave. Everything is evaluated on the falling edge; inputs
  // only change there, so "VALID && READY" here is exactly the handshake
  // the DUT sees on the following rising edge.
  initial begin : slave
    int  ar_c, r_c, aw_c, w_c, b_c;
    bit  r_pend, aw_got, w_got, b_pend;
    axi.ARREADY = 0; axi.RVALID = 0; axi.RDATA = 0; axi.RRESP = 0;
    axi.AWREADY = 0; axi.WREADY = 0; axi.BVALID = 0; axi.BRESP = 0;
    stall_cnt = 0; ar_seen = 0; aw_seen = 0; b_hs = 0;
    ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
    r_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
    got_araddr = 0; got_awaddr = 0; got_wdata = 0; got_arsize = 0; got_awsize = 0;
    got_arlen = 0; got_awlen = 0; got_strb = 0; got_arid = 0;
    got_arburst = 0; got_awburst = 0; got_wlast = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        axi.ARREADY = 0; axi.RVALID = 0; axi.AWREADY = 0; axi.WREADY = 0; axi.BVALID = 0;
        ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
        r_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
      end else begin
        if (stall)       stall_cnt++;
        if (axi.ARVALID) ar_seen++;
        if (axi.AWVALID) aw_seen++;
        // R before AR so data never appears in the address-handshake cycle.
        axi.RVALID = r_pend && (r_c >= r_d);
        axi.RDATA  = axi.RVALID ? s_rdata : 32'h0;
        axi.RRESP  = axi.RVALID ? s_resp : 2'b00;
        if (axi.RVALID && axi.RREADY) r_pend = 0;
        else if (r_pend)              r_c++;
        axi.ARREADY = axi.ARVALID && (ar_c >= ar_d);
        if (axi.ARVALID && axi.ARREADY) begin
          got_araddr = axi.ARADDR; got_arsize = axi.ARSIZE; got_arlen = axi.ARLEN;
          got_arburst = axi.ARBURST; got_arid = axi.ARID;
          ar_c = 0; r_pend = 1; r_c = 0;
        end else if (axi.ARVALID) ar_c++;
        // B before AW/W for the same reason.
        axi.BVALID = b_pend && (b_c >= b_d);
        axi.BRESP  = axi.BVALID ? s_resp : 2'b00;
        if (axi.BVALID && axi.BREADY) begin b_pend = 0; b_hs++; end
        else if (b_pend)              b_c++;
        axi.AWREADY = axi.AWVALID && (aw_c >= aw_d);
        if (axi.AWVALID && axi.AWREADY) begin
          got_awaddr = axi.AWADDR; got_awsize = axi.AWSIZE; got_awlen = axi.AWLEN;
          got_awburst = axi.AWBURST; aw_got = 1; aw_c = 0;
        end else if (axi.AWVALID) aw_c++;
        axi.WREADY = axi.WVALID && (w_c >= w_d);
        if (axi.WVALID && axi.WREADY) begin
          got_wdata = axi.WDATA; got_strb = axi.WSTRB; got_wlast = axi.WLAST;
          w_got = 1; w_c = 0;
        end else if (axi.WVALID) w_c++;
        if (aw_got && w_got) begin b_pend = 1; b_c = 0; aw_got = 0; w_got = 0; end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model state.
  logic [31:0] exp_rdata;
  logic        exp_err;

  // One CPU transaction from IDLE through DONE, checked against the model.
  task automatic run_txn(input string tag, input bit rd, input bit wr,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] ct, input logic [31:0] rdat,
                         input logic [1:0] resp);
    int  e_size, nbytes, off, e_stall, s0_stall, s0_ar, s0_aw, s0_b;
    logic [31:0] e_strb;
    bit  is_wr, done;
    e_size = (ct == 3'd1) ? 1 : (ct == 3'd2) ? 0 : 2;
    nbytes = 1 << e_size;
    off    = int'(addr[1:0]);
    off    = off - (off % nbytes);
    e_strb = ((32'd1 << nbytes) - 1) << off;
    is_wr  = wr;
    if (is_wr) begin
      e_stall = 1 + ((aw_d > w_d ? aw_d : w_d) + 1) + (b_d + 1);
    end else begin
      e_stall = 1 + (ar_d + 1) + (r_d + 1);
`ifdef CPU_AXI_MASTER_RESP_CHECK_EN
      exp_rdata = (resp != 2'b00) ? 32'h0 : rdat;
`else
      exp_rdata = rdat;
`endif
    end
`ifdef CPU_AXI_MASTER_RESP_CHECK_EN
    if (resp != 2'b00) exp_err = 1'b1;
`endif
    s_rdata = rdat; s_resp = resp;
    s0_stall = stall_cnt; s0_ar = ar_seen; s0_aw = aw_seen; s0_b = b_hs;
    req_read = rd; req_write = wr; req_addr = addr; req_wdata = wdata; req_core_type = ct;
    done = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (!stall) begin done = 1; break; end
    end
    check({tag, "_completes"}, 32'(done), 32'd1);
    check({tag, "_stall_cycles"}, 32'(stall_cnt - s0_stall), 32'(e_stall));
    check({tag, "_rdata"}, req_rdata, exp_rdata);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    if (is_wr) begin
      check({tag, "_ar_seen"}, 32'(ar_seen - s0_ar), 32'd0);
      check({tag, "_b_hs"}, 32'(b_hs - s0_b), 32'd1);
      check({tag, "_awaddr"}, got_awaddr, addr);
      check({tag, "_awsize"}, 32'(got_awsize), 32'(e_size));
      check({tag, "_awlen_burst"}, {got_awlen, 2'b00, got_awburst}, {4'd0, 2'b00, 2'b01});
      check({tag, "_wstrb"}, 32'(got_strb), e_strb);
      check({tag, "_wdata_wlast"}, {got_wdata[30:0], got_wlast}, {wdata[30:0], 1'b1});
    end else begin
      check({tag, "_aw_seen"}, 32'(aw_seen - s0_aw), 32'd0);
      check({tag, "_araddr"}, got_araddr, addr);
      check({tag, "_arsize"}, 32'(got_arsize), 32'(e_size));
      check({tag, "_arid_len_burst"}, {got_arid, got_arlen, got_arburst}, {4'd0, 4'd0, 2'b01});
    end
    // DONE still shows the retiring request; it is withdrawn once back in IDLE.
    @(posedge clk); #1;
    req_read = 0; req_write = 0;
  endtask

  initial begin : main
    int s_ar, s_aw, s_st;
    bit ok;
    rst = 1; req_read = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_core_type = 0;
    ar_d = 0; r_d = 0; aw_d = 0; w_d = 0; b_d = 0; s_rdata = 0; s_resp = 0;
    exp_rdata = 0; exp_err = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valids", {27'd0, axi.ARVALID, axi.RREADY, axi.AWVALID, axi.WVALID, axi.BREADY}, 32'd0);
    check("rst_stall_err", {30'd0, stall, err}, 32'd0);
    check("rst_rdata", req_rdata, 32'd0);
    check("rst_araddr", axi.ARADDR, 32'd0);
    check("rst_wdata", axi.WDATA, 32'd0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    // Minimum-latency word read.
    run_txn("rd_word", 1, 0, 32'h0000_0010, 32'h0, 3'd0, 32'hDEAD_BEEF, 2'b00);
    check("rd_word_value", req_rdata, 32'hDEAD_BEEF);

    // No new transaction while idle once the request has been withdrawn.
    s_ar = ar_seen; s_aw = aw_seen; s_st = stall_cnt;
    repeat (3) @(posedge clk);
    #1;
    check("idle_no_txn", 32'((ar_seen - s_ar) + (aw_seen - s_aw) + (stall_cnt - s_st)), 32'd0);

    // Byte write with WREADY four cycles behind AWREADY.
    w_d = 4;
    s_aw = aw_seen;
    run_txn("wr_byte", 0, 1, 32'h0000_0023, 32'hAB00_0000, 3'd2, 32'h0, 2'b00);
    check("wr_byte_strb", 32'(got_strb), 32'h8);
    check("wr_byte_aw_cycles", 32'(aw_seen - s_aw), 32'd1);
    w_d = 0;

    // Simultaneous read and write: the write wins.
    run_txn("rw_both", 1, 1, 32'h0000_0040, 32'h1234_5678, 3'd0, 32'h5555_AAAA, 2'b00);

    // Halfword read answered with SLVERR.
    run_txn("rd_half_err", 1, 0, 32'h0000_0006, 32'h0, 3'd1, 32'hCAFE_F00D, 2'b10);

    // Reset while waiting for read data.
    r_d = 8;
    req_read = 1; req_write = 0; req_addr = 32'h80; req_core_type = 3'd0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (axi.RREADY) begin ok = 1; break; end
    end
    check("rst_mid_reached_rd_data", 32'(ok), 32'd1);
    rst = 1;
    #1;
    check("rst_mid_outputs", {29'd0, axi.ARVALID, axi.RREADY, stall}, 32'd0);
    check("rst_mid_rdata_err", {req_rdata[30:0], err}, 32'd0);
    req_read = 0;
    exp_rdata = 0; exp_err = 0;
    @(posedge clk); #1;
    rst = 0; r_d = 0;
    @(posedge clk); #1;
    run_txn("rd_after_rst", 1, 0, 32'h0000_0084, 32'h0, 3'd0, 32'h0BAD_C0DE, 2'b00);

    // Randomized traffic with random wait states and occasional error responses.
    for (int k = 0; k < 24; k++) begin
      int sel;
      logic [1:0] rsp;
      ar_d = $urandom_range(0, 3); r_d = $urandom_range(0, 3);
      aw_d = $urandom_range(0, 3); w_d = $urandom_range(0, 3); b_d = $urandom_range(0, 3);
      sel = $urandom_range(0, 2);
      rsp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_txn($sformatf("rnd%0d", k), sel != 1, sel != 0, $urandom, $urandom,
              3'($urandom_range(0, 4)), $urandom, rsp);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
